// File: rtl/freq_counter_pkg.sv
// rtl/freq_counter_pkg.sv - shared types and constants for the frequency counter BCD path
package freq_counter_pkg;

    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t DIGIT_BLANK = 4'hF;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } bcd_state_e;

    function automatic logic [63:0] pow10_64(input int unsigned n);
        logic [63:0] r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/freq_bin_to_bcd_adj3.sv
// rtl/freq_bin_to_bcd_adj3.sv - double-dabble add-3-if-ge-5 correction for one BCD digit
module bcd_digit_adj3
    import freq_counter_pkg::*;
(
    input  bcd_digit_t digit_in,
    output bcd_digit_t digit_out
);

    assign digit_out = (digit_in >= 4'd5) ? (digit_in + 4'd3) : digit_in;

endmodule

// File: rtl/freq_bin_to_bcd.sv
// rtl/freq_bin_to_bcd.sv - iterative binary-to-packed-BCD converter, one shift per input bit
// Optional build macro FREQ_BCD_LEADING_BLANK_EN replaces leading zero digits with DIGIT_BLANK.
module freq_bin_to_bcd
    import freq_counter_pkg::*;
#(
    parameter int BIN_W  = 27,
    parameter int DIGITS = 8
) (
    input  logic                  clk_in,
    input  logic                  rstn_in,
    input  logic [BIN_W-1:0]      bin_in,
    input  logic                  start_in,
    output logic                  busy_out,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  valid_out,
    output logic                  overflow_out
);

    localparam int          ACC_W     = 4 * DIGITS;
    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam logic [63:0] OVF_LIMIT = pow10_64(DIGITS);

    bcd_state_e         state_q;
    logic [BIN_W-1:0]   sh_q;
    logic [ACC_W-1:0]   acc_q;
    logic [ACC_W-1:0]   acc_adj;
    logic [ACC_W-1:0]   result_d;
    logic [CNT_W-1:0]   cnt_q;
    logic               ovf_q;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj3 u_adj (
            .digit_in  (acc_q[4*g +: 4]),
            .digit_out (acc_adj[4*g +: 4])
        );
    end

`ifdef FREQ_BCD_LEADING_BLANK_EN
    logic lead;
`endif

    // Value presented to the output register in DONE; saturation wins over blanking.
    always_comb begin
        result_d = ovf_q ? {DIGITS{4'h9}} : acc_q;
`ifdef FREQ_BCD_LEADING_BLANK_EN
        lead = !ovf_q;
        for (int i = DIGITS - 1; i > 0; i--) begin
            if (lead && (acc_q[4*i +: 4] == 4'h0)) begin
                result_d[4*i +: 4] = DIGIT_BLANK;
            end else begin
                lead = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk_in or negedge rstn_in) begin
        if (!rstn_in) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            busy_out     <= 1'b0;
            valid_out    <= 1'b0;
            bcd_out      <= '0;
            overflow_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_in) begin
                        sh_q     <= bin_in;
                        acc_q    <= '0;
                        cnt_q    <= CNT_W'(BIN_W);
                        ovf_q    <= (64'(bin_in) >= OVF_LIMIT);
                        busy_out <= 1'b1;
                        state_q  <= SHIFT;
                    end
                end
                SHIFT: begin
                    // Top-digit carry is dropped; only saturated inputs can produce one.
                    acc_q <= {acc_adj[ACC_W-2:0], sh_q[BIN_W-1]};
                    sh_q  <= sh_q << 1;
                    cnt_q <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    bcd_out      <= result_d;
                    overflow_out <= ovf_q;
                    valid_out    <= 1'b1;
                    busy_out     <= 1'b0;
                    state_q      <= IDLE;
                end
                default: begin
                    state_q  <= IDLE;
                    busy_out <= 1'b0;
                end
            endcase
        end
    end

endmodule
